// File: rtl/dti_pr_tniu_async_noc_side.sv
// NoC-side half of a dual-clock TNIU link: request FIFO write port with local storage,
// response FIFO read port against far-side storage, Johnson-coded crossing pointers.
module dti_pr_tniu_async_noc_side #(
    parameter int ASYNC_FIFO_DEPTH = 16,
    parameter int SYNC_STAGES      = 2
) (
    input  logic                        clk,
    input  logic                        rst_n,

    input  logic                        req_valid,
    input  logic [89:0]                 req_payload,
    input  logic                        req_last,
    input  logic [5:0]                  req_srcid,
    input  logic [5:0]                  req_tgtid,
    input  logic                        req_qos,
    output logic                        req_ready,
    output logic                        req_threshold,
    output logic [ASYNC_FIFO_DEPTH-1:0] req_wptr_async,
    input  logic [ASYNC_FIFO_DEPTH-1:0] req_rptr_async,
    input  logic [ASYNC_FIFO_DEPTH-1:0] req_rptr_sync,
    output logic [104:0]                req_pld_sync,

    output logic                        rsp_valid,
    output logic [89:0]                 rsp_payload,
    output logic                        rsp_last,
    output logic [5:0]                  rsp_srcid,
    output logic [5:0]                  rsp_tgtid,
    output logic                        rsp_qos,
    input  logic                        rsp_ready,
    input  logic                        rsp_threshold,
    input  logic [ASYNC_FIFO_DEPTH-1:0] rsp_wptr_async,
    output logic [ASYNC_FIFO_DEPTH-1:0] rsp_rptr_async,
    output logic [ASYNC_FIFO_DEPTH-1:0] rsp_rptr_sync,
    input  logic [104:0]                rsp_pld_sync,
    output logic                        rsp_par_err,

    output logic                        idle
);

    localparam int D  = ASYNC_FIFO_DEPTH;
    localparam int IW = $clog2(ASYNC_FIFO_DEPTH);
    localparam int CW = $clog2(ASYNC_FIFO_DEPTH + 1);
    localparam logic [CW-1:0] DEPTH_C = CW'(ASYNC_FIFO_DEPTH);

    function automatic logic [D-1:0] jinc(input logic [D-1:0] p);
        return {p[D-2:0], ~p[D-1]};
    endfunction

    // Johnson state to storage slot: rising half counts ones, falling half counts back down.
    function automatic logic [IW-1:0] jidx(input logic [D-1:0] p);
        logic [CW-1:0] cnt;
        cnt = '0;
        for (int i = 0; i < D; i++) begin
            cnt = cnt + {{(CW-1){1'b0}}, p[i]};
        end
        if (p[D-1]) begin
            return IW'(DEPTH_C - cnt);
        end else begin
            return IW'(cnt);
        end
    endfunction

    function automatic logic par_even(input logic [103:0] d);
        return ^d;
    endfunction

    function automatic logic [103:0] pack(input logic [89:0] pl, input logic [5:0] src,
                                          input logic [5:0] tgt, input logic qos,
                                          input logic last);
        return {pl, src, tgt, qos, last};
    endfunction

    logic [103:0] mem_r [D];
    logic [D-1:0] wptr_r;
    logic [D-1:0] rptr_r;
    logic [D-1:0] req_sync_r [SYNC_STAGES];
    logic [D-1:0] rsp_sync_r [SYNC_STAGES];
    logic         full_r;
    logic         valid_r;
    logic         par_err_r;
    logic         idle_r;

    logic [D-1:0] rptr_s;
    logic [D-1:0] wptr_s;
    logic [D-1:0] wptr_nxt_s;
    logic [D-1:0] rptr_nxt_s;
    logic         push_s;
    logic         pop_s;
    logic         par_bad_s;
    logic [103:0] req_data_s;
    logic [103:0] sel_data_s;
    logic         unused_s;

    assign rptr_s = req_sync_r[SYNC_STAGES-1];
    assign wptr_s = rsp_sync_r[SYNC_STAGES-1];

    // Handshakes and next pointer values; push is held off while reset is asserted.
    always_comb begin
        push_s     = req_valid & ~full_r & rst_n;
        pop_s      = valid_r & rsp_ready & rst_n;
        req_data_s = pack(req_payload, req_srcid, req_tgtid, req_qos, req_last);
        par_bad_s  = rsp_pld_sync[104] ^ par_even(rsp_pld_sync[103:0]);
        if (push_s) begin
            wptr_nxt_s = jinc(wptr_r);
        end else begin
            wptr_nxt_s = wptr_r;
        end
        if (pop_s) begin
            rptr_nxt_s = jinc(rptr_r);
        end else begin
            rptr_nxt_s = rptr_r;
        end
    end

    // Pointer synchronizers for both crossings.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                req_sync_r[i] <= '0;
                rsp_sync_r[i] <= '0;
            end
        end else begin
            req_sync_r[0] <= req_rptr_async;
            rsp_sync_r[0] <= rsp_wptr_async;
            for (int i = 1; i < SYNC_STAGES; i++) begin
                req_sync_r[i] <= req_sync_r[i-1];
                rsp_sync_r[i] <= rsp_sync_r[i-1];
            end
        end
    end

    // Pointers and status flags; flags compare against the lagging synced pointer, so they only err safe.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wptr_r    <= '0;
            rptr_r    <= '0;
            full_r    <= 1'b0;
            valid_r   <= 1'b0;
            par_err_r <= 1'b0;
            idle_r    <= 1'b1;
        end else begin
            wptr_r    <= wptr_nxt_s;
            rptr_r    <= rptr_nxt_s;
            full_r    <= (wptr_nxt_s == ~rptr_s);
            valid_r   <= (rptr_nxt_s != wptr_s);
            par_err_r <= pop_s & par_bad_s;
            idle_r    <= (wptr_nxt_s == rptr_s) & (rptr_nxt_s == wptr_s);
        end
    end

    // Request storage is deliberately not reset; a slot is only read after the far side sees it written.
    always_ff @(posedge clk) begin
        if (push_s) begin
            mem_r[jidx(wptr_r)] <= req_data_s;
        end
    end

    assign sel_data_s    = mem_r[jidx(req_rptr_sync)];
    assign req_pld_sync  = {par_even(sel_data_s), sel_data_s};
    assign req_ready     = ~full_r;
    assign req_threshold = 1'b1;
    assign req_wptr_async = wptr_r;

    assign rsp_valid      = valid_r;
    assign rsp_payload    = rsp_pld_sync[103:14];
    assign rsp_srcid      = rsp_pld_sync[13:8];
    assign rsp_tgtid      = rsp_pld_sync[7:2];
    assign rsp_qos        = rsp_pld_sync[1];
    assign rsp_last       = rsp_pld_sync[0];
    assign rsp_rptr_async = rptr_r;
    assign rsp_rptr_sync  = rptr_r;
    assign rsp_par_err    = par_err_r;
    assign idle           = idle_r;

    assign unused_s = rsp_threshold;

endmodule

// File: tb/tb_dti_pr_tniu_async_noc_side.sv
// Scoreboard bench: far-side reader/writer models around the NoC-side FIFO halves.
module tb_dti_pr_tniu_async_noc_side;

    localparam int D = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic [89:0]   req_payload;
    logic          req_last;
    logic [5:0]    req_srcid;
    logic [5:0]    req_tgtid;
    logic          req_qos;
    logic          req_ready;
    logic          req_threshold;
    logic [D-1:0]  req_wptr_async;
    logic [D-1:0]  req_rptr_async;
    logic [D-1:0]  req_rptr_sync;
    logic [104:0]  req_pld_sync;
    logic          rsp_valid;
    logic [89:0]   rsp_payload;
    logic          rsp_last;
    logic [5:0]    rsp_srcid;
    logic [5:0]    rsp_tgtid;
    logic          rsp_qos;
    logic          rsp_ready;
    logic          rsp_threshold;
    logic [D-1:0]  rsp_wptr_async;
    logic [D-1:0]  rsp_rptr_async;
    logic [D-1:0]  rsp_rptr_sync;
    logic [104:0]  rsp_pld_sync;
    logic          rsp_par_err;
    logic          idle;

    int            checks;
    int            failures;
    logic [104:0]  req_q[$];
    logic [104:0]  rsp_q[$];
    logic [104:0]  rmem [D];
    logic [D-1:0]  far_wptr;
    logic [D-1:0]  far_rptr;

    always #5 clk = ~clk;

    function automatic logic [D-1:0] jinc(input logic [D-1:0] p);
        return {p[D-2:0], ~p[D-1]};
    endfunction

    function automatic int jidx(input logic [D-1:0] p);
        int ones;
        ones = 0;
        for (int i = 0; i < D; i++) ones += int'(p[i]);
        return p[D-1] ? (D - ones) % D : ones;
    endfunction

    function automatic logic [104:0] pk(input logic [89:0] pl, input logic [5:0] s,
                                        input logic [5:0] t, input logic q, input logic l);
        logic [103:0] d;
        d = {pl, s, t, q, l};
        return {^d, d};
    endfunction

    function automatic logic [89:0] rand_pl();
        logic [95:0] t;
        t = {$urandom(), $urandom(), $urandom()};
        return t[89:0];
    endfunction

    assign rsp_pld_sync = rmem[jidx(rsp_rptr_sync)];

    dti_pr_tniu_async_noc_side #(.ASYNC_FIFO_DEPTH(16), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_payload(req_payload), .req_last(req_last),
        .req_srcid(req_srcid), .req_tgtid(req_tgtid), .req_qos(req_qos),
        .req_ready(req_ready), .req_threshold(req_threshold),
        .req_wptr_async(req_wptr_async), .req_rptr_async(req_rptr_async),
        .req_rptr_sync(req_rptr_sync), .req_pld_sync(req_pld_sync),
        .rsp_valid(rsp_valid), .rsp_payload(rsp_payload), .rsp_last(rsp_last),
        .rsp_srcid(rsp_srcid), .rsp_tgtid(rsp_tgtid), .rsp_qos(rsp_qos),
        .rsp_ready(rsp_ready), .rsp_threshold(rsp_threshold),
        .rsp_wptr_async(rsp_wptr_async), .rsp_rptr_async(rsp_rptr_async),
        .rsp_rptr_sync(rsp_rptr_sync), .rsp_pld_sync(rsp_pld_sync),
        .rsp_par_err(rsp_par_err), .idle(idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(output logic [104:0] e);
        logic [31:0] r;
        r = $urandom();
        req_payload = rand_pl();
        req_srcid   = r[5:0];
        req_tgtid   = r[13:8];
        req_qos     = r[16];
        req_last    = r[20];
        e = pk(req_payload, req_srcid, req_tgtid, req_qos, req_last);
    endtask

    task automatic drive_far_zero();
        far_wptr = '0;
        far_rptr = '0;
        req_rptr_async = '0;
        req_rptr_sync  = '0;
        rsp_wptr_async = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        drive_far_zero();
        req_q.delete();
        rsp_q.delete();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        drive_far_zero();
        tick();
        tick();
        for (int ph = 0; ph < 2; ph++) begin
            checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL reset_req_ready ph%0d got=%b exp=1", ph, req_ready); end
            checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid ph%0d got=%b exp=0", ph, rsp_valid); end
            checks++; if (rsp_par_err !== 1'b0) begin failures++; $display("FAIL reset_par_err ph%0d got=%b exp=0", ph, rsp_par_err); end
            checks++; if (idle !== 1'b1) begin failures++; $display("FAIL reset_idle ph%0d got=%b exp=1", ph, idle); end
            checks++; if (req_wptr_async !== 16'h0000) begin failures++; $display("FAIL reset_wptr ph%0d got=%h exp=0000", ph, req_wptr_async); end
            checks++; if (rsp_rptr_async !== 16'h0000) begin failures++; $display("FAIL reset_rptr ph%0d got=%h exp=0000", ph, rsp_rptr_async); end
            checks++; if (req_threshold !== 1'b1) begin failures++; $display("FAIL threshold ph%0d got=%b exp=1", ph, req_threshold); end
            rst_n = 1'b1;
            tick();
        end
    endtask

    task automatic test_fill();
        logic [104:0] e;
        logic [D-1:0] exp_w;
        exp_w = '0;
        for (int i = 0; i < 16; i++) begin
            set_beat(e);
            req_valid = 1'b1;
            checks++;
            if (req_ready !== 1'b1) begin
                failures++; $display("FAIL fill_ready beat%0d got=%b exp=1", i, req_ready);
            end else begin
                req_q.push_back(e);
                exp_w = jinc(exp_w);
            end
            tick();
            checks++; if (req_wptr_async !== exp_w) begin failures++; $display("FAIL fill_wptr beat%0d got=%h exp=%h", i, req_wptr_async, exp_w); end
        end
        checks++; if (req_wptr_async !== 16'hFFFF) begin failures++; $display("FAIL fill_full_wptr got=%h exp=ffff", req_wptr_async); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL fill_full_ready got=%b exp=0", req_ready); end
        set_beat(e);
        tick();
        req_valid = 1'b0;
        checks++; if (req_wptr_async !== 16'hFFFF) begin failures++; $display("FAIL fill_17th_wptr got=%h exp=ffff", req_wptr_async); end
        checks++; if (req_ready !== 1'b0) begin failures++; $display("FAIL fill_17th_ready got=%b exp=0", req_ready); end
        checks++; if (idle !== 1'b0) begin failures++; $display("FAIL fill_idle got=%b exp=0", idle); end
    endtask

    task automatic test_drain_release();
        logic [104:0] e;
        req_rptr_async = 16'h0001;
        req_rptr_sync  = 16'h0000;
        #1;
        e = req_q.pop_front();
        checks++; if (req_pld_sync !== e) begin failures++; $display("FAIL drain_entry0 got=%h exp=%h", req_pld_sync, e); end
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (req_ready !== (c == 3)) begin
                failures++; $display("FAIL drain_ready_lag cycle%0d got=%b exp=%b", c, req_ready, (c == 3));
            end
        end
        req_rptr_sync = 16'h0001;
        #1;
        e = req_q.pop_front();
        checks++; if (req_pld_sync !== e) begin failures++; $display("FAIL drain_entry1 got=%h exp=%h", req_pld_sync, e); end
    endtask

    task automatic test_response();
        logic [104:0] e;
        do_reset();
        e = pk(rand_pl(), 6'd3, 6'd5, 1'b1, 1'b1);
        rmem[0] = e;
        rsp_q.push_back(e);
        far_wptr = jinc(far_wptr);
        rsp_wptr_async = far_wptr;
        for (int c = 1; c <= 3; c++) begin
            tick();
            checks++;
            if (rsp_valid !== (c == 3)) begin
                failures++; $display("FAIL rsp_valid_lag cycle%0d got=%b exp=%b", c, rsp_valid, (c == 3));
            end
        end
        for (int c = 0; c < 5; c++) begin
            checks++;
            if ({rsp_valid, rsp_payload, rsp_srcid, rsp_tgtid, rsp_qos, rsp_last} !== {1'b1, rsp_q[0][103:0]}) begin
                failures++; $display("FAIL rsp_hold cycle%0d got=%b_%h exp=1_%h", c, rsp_valid,
                    {rsp_payload, rsp_srcid, rsp_tgtid, rsp_qos, rsp_last}, rsp_q[0][103:0]);
            end
            if (c < 4) tick();
        end
        rsp_ready = 1'b1;
        e = rsp_q.pop_front();
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_rptr_async !== 16'h0001) begin failures++; $display("FAIL rsp_pop_rptr got=%h exp=0001", rsp_rptr_async); end
        checks++; if (rsp_rptr_sync !== 16'h0001) begin failures++; $display("FAIL rsp_pop_rptr_sync got=%h exp=0001", rsp_rptr_sync); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL rsp_pop_valid got=%b exp=0", rsp_valid); end
        checks++; if (rsp_par_err !== 1'b0) begin failures++; $display("FAIL rsp_good_parity got=%b exp=0", rsp_par_err); end
    endtask

    task automatic test_parity();
        logic [104:0] e;
        e = pk(rand_pl(), 6'd9, 6'd17, 1'b0, 1'b1);
        e[104] = ~e[104];
        rmem[jidx(far_wptr)] = e;
        far_wptr = jinc(far_wptr);
        rsp_wptr_async = far_wptr;
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 1'b1) begin failures++; $display("FAIL par_valid got=%b exp=1", rsp_valid); end
        checks++; if (rsp_par_err !== 1'b0) begin failures++; $display("FAIL par_before_pop got=%b exp=0", rsp_par_err); end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        checks++; if (rsp_par_err !== 1'b1) begin failures++; $display("FAIL par_pulse got=%b exp=1", rsp_par_err); end
        tick();
        checks++; if (rsp_par_err !== 1'b0) begin failures++; $display("FAIL par_one_cycle got=%b exp=0", rsp_par_err); end
    endtask

    task automatic test_stream();
        logic [104:0] e;
        logic [104:0] x;
        logic [D-1:0] exp_w;
        logic [D-1:0] pw;
        logic [D-1:0] pr;
        int sent_q, got_q, sent_r, got_r, zw, zr;
        do_reset();
        exp_w = '0; pw = '0; pr = '0;
        sent_q = 0; got_q = 0; sent_r = 0; got_r = 0; zw = 1; zr = 1;
        for (int cyc = 0; cyc < 4000 && !(got_q == 40 && got_r == 40); cyc++) begin
            checks++; if (req_wptr_async !== exp_w) begin failures++; $display("FAIL stream_wptr cyc%0d got=%h exp=%h", cyc, req_wptr_async, exp_w); end
            if (req_wptr_async == 16'h0000 && pw != 16'h0000) zw++;
            if (rsp_rptr_async == 16'h0000 && pr != 16'h0000) zr++;
            pw = req_wptr_async;
            pr = rsp_rptr_async;
            if (req_q.size() > 0 && $urandom_range(0, 2) == 0) begin
                e = req_q.pop_front();
                checks++; if (req_pld_sync !== e) begin failures++; $display("FAIL stream_req_data beat%0d got=%h exp=%h", got_q, req_pld_sync, e); end
                far_rptr = jinc(far_rptr);
                req_rptr_async = far_rptr;
                req_rptr_sync  = far_rptr;
                got_q++;
            end
            req_valid = 1'b0;
            if (sent_q < 40 && $urandom_range(0, 1) == 0) begin
                set_beat(e);
                req_valid = 1'b1;
                if (req_ready === 1'b1) begin
                    req_q.push_back(e);
                    exp_w = jinc(exp_w);
                    sent_q++;
                end
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            if (rsp_valid === 1'b1 && rsp_ready) begin
                checks++;
                if (rsp_q.size() == 0) begin
                    failures++; $display("FAIL stream_rsp_unwritten got=valid exp=empty");
                end else begin
                    x = rsp_q.pop_front();
                    if ({rsp_payload, rsp_srcid, rsp_tgtid, rsp_qos, rsp_last} !== x[103:0]) begin
                        failures++; $display("FAIL stream_rsp_data beat%0d got=%h exp=%h", got_r,
                            {rsp_payload, rsp_srcid, rsp_tgtid, rsp_qos, rsp_last}, x[103:0]);
                    end
                end
                got_r++;
            end
            if (sent_r < 40 && far_wptr != ~rsp_rptr_async && $urandom_range(0, 2) != 0) begin
                x = pk(rand_pl(), 6'(sent_r), 6'(63 - sent_r), sent_r[0], sent_r[1]);
                rmem[jidx(far_wptr)] = x;
                rsp_q.push_back(x);
                far_wptr = jinc(far_wptr);
                rsp_wptr_async = far_wptr;
                sent_r++;
            end
            tick();
            checks++; if (rsp_par_err !== 1'b0) begin failures++; $display("FAIL stream_par_err got=%b exp=0", rsp_par_err); end
        end
        req_valid = 1'b0;
        rsp_ready = 1'b0;
        checks++; if (got_q != 40 || got_r != 40) begin failures++; $display("FAIL stream_timeout got=%0d/%0d exp=40/40", got_q, got_r); end
        checks++; if (req_wptr_async !== 16'h00FF) begin failures++; $display("FAIL stream_final_wptr got=%h exp=00ff", req_wptr_async); end
        checks++; if (rsp_rptr_async !== 16'h00FF) begin failures++; $display("FAIL stream_final_rptr got=%h exp=00ff", rsp_rptr_async); end
        checks++; if (zw != 2 || zr != 2) begin failures++; $display("FAIL stream_zero_pass got=%0d/%0d exp=2/2", zw, zr); end
        tick(); tick(); tick(); tick();
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL stream_idle got=%b exp=1", idle); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL stream_empty got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL stream_ready got=%b exp=1", req_ready); end
    endtask

    task automatic test_reset_midstream();
        logic [104:0] e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            set_beat(e);
            req_valid = 1'b1;
            tick();
            rmem[jidx(far_wptr)] = e;
            far_wptr = jinc(far_wptr);
        end
        req_valid = 1'b0;
        rsp_wptr_async = far_wptr;
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 1'b1 || idle !== 1'b0) begin failures++; $display("FAIL mid_pre_state got=%b%b exp=10", rsp_valid, idle); end
        checks++; if (req_wptr_async !== 16'h001F) begin failures++; $display("FAIL mid_pre_wptr got=%h exp=001f", req_wptr_async); end
        rst_n = 1'b0;
        drive_far_zero();
        tick();
        checks++; if (req_wptr_async !== 16'h0000) begin failures++; $display("FAIL mid_wptr got=%h exp=0000", req_wptr_async); end
        checks++; if (rsp_rptr_async !== 16'h0000) begin failures++; $display("FAIL mid_rptr got=%h exp=0000", rsp_rptr_async); end
        checks++; if (rsp_valid !== 1'b0) begin failures++; $display("FAIL mid_rsp_valid got=%b exp=0", rsp_valid); end
        checks++; if (req_ready !== 1'b1) begin failures++; $display("FAIL mid_req_ready got=%b exp=1", req_ready); end
        checks++; if (idle !== 1'b1) begin failures++; $display("FAIL mid_idle got=%b exp=1", idle); end
        rst_n = 1'b1;
        tick(); tick(); tick();
        checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin failures++; $display("FAIL mid_after got=%b%b exp=01", rsp_valid, idle); end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst_n = 1'b0;
        req_valid = 1'b0;
        req_payload = '0;
        req_last = 1'b0;
        req_srcid = '0;
        req_tgtid = '0;
        req_qos = 1'b0;
        rsp_ready = 1'b0;
        rsp_threshold = 1'b0;
        for (int i = 0; i < D; i++) rmem[i] = '0;
        drive_far_zero();
        test_reset();
        test_fill();
        test_drain_release();
        test_response();
        test_parity();
        test_stream();
        test_reset_midstream();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
